range_to_pwm: RTL and testbench

Upstream feeder for the PWM generator. It takes 8-bit range samples (mm) from the VL6180X readout path and maps them linearly onto a PWM duty threshold, with clamping, optional inversion and exponential smoothing. Its outputs connect directly to the PWM stage: PWM_COUNTER drives the period top and PWM_PERIOD drives the duty compare threshold. The multiply and divide are multi-cycle, so no DSP blocks are needed on iCE40.

---
 rtl/range_to_pwm_if.sv | 21 ++
 rtl/range_to_pwm.sv | 161 ++++++++++++++++
 tb/tb_range_to_pwm.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/range_to_pwm_if.sv
// Range-sample handshake between the VL6180X readout path and range_to_pwm.
interface range_to_pwm_if;
    logic [7:0] RANGE_DATA;
    logic       RANGE_ERR;
    logic       RANGE_VALID;
    logic       RANGE_READY;

    modport master (
        output RANGE_DATA,
        output RANGE_ERR,
        output RANGE_VALID,
        input  RANGE_READY
    );

    modport slave (
        input  RANGE_DATA,
        input  RANGE_ERR,
        input  RANGE_VALID,
        output RANGE_READY
    );
endinterface

// File: rtl/range_to_pwm.sv
// Maps 8-bit range samples onto a PWM duty threshold: clamp, optional invert,
// multi-cycle shift-add multiply and restoring divide, then optional IIR smoothing.
module range_to_pwm #(
    parameter logic [31:0] PWM_TOP      = 32'd11999,
    parameter logic [7:0]  RANGE_MIN    = 8'd10,
    parameter logic [7:0]  RANGE_MAX    = 8'd200,
    parameter bit          INVERT       = 1'b1,
    parameter int unsigned SMOOTH_SHIFT = 0
) (
    input  logic                 CLK,
    input  logic                 RST,
    range_to_pwm_if.slave        rng,
    output logic [31:0]          PWM_COUNTER,
    output logic [31:0]          PWM_PERIOD,
    output logic                 UPDATE,
    output logic                 BUSY
);

    typedef enum logic [2:0] {IDLE, PREP, MUL, DIV, SMOOTH} state_t;

    localparam logic [7:0]  SPAN  = RANGE_MAX - RANGE_MIN;
    localparam logic [40:0] MCAND = 41'(PWM_TOP) + 41'd1;
    localparam logic [33:0] SNAP  = 34'd1 << SMOOTH_SHIFT;

    state_t        state_q, state_d;
    logic [7:0]    data_q, data_d;
    logic          err_q, err_d;
    logic [7:0]    mplier_q, mplier_d;
    logic [40:0]   mcand_q, mcand_d;
    logic [40:0]   prod_q, prod_d;
    logic [7:0]    rem_q, rem_d;
    logic [5:0]    cnt_q, cnt_d;
    logic [31:0]   period_q, period_d;
    logic          update_q, update_d;

    logic          transfer;
    logic [7:0]    r_clamp;
    logic [7:0]    offset;
    logic [8:0]    rem_sh;
    logic          ge;
    logic [32:0]   target;
    logic signed [33:0] diff;
    logic signed [33:0] step;
    logic signed [33:0] sum;
    logic [33:0]   mag;

    assign rng.RANGE_READY = (state_q == IDLE) & ~RST;
    assign transfer        = rng.RANGE_VALID & rng.RANGE_READY;
    assign BUSY            = (state_q != IDLE);
    assign PWM_COUNTER     = PWM_TOP;
    assign PWM_PERIOD      = period_q;
    assign UPDATE          = update_q;

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        err_d    = err_q;
        mplier_d = mplier_q;
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        update_d = 1'b0;
        r_clamp  = '0;
        offset   = '0;
        rem_sh   = '0;
        ge       = 1'b0;
        target   = '0;
        diff     = '0;
        step     = '0;
        sum      = '0;
        mag      = '0;

        case (state_q)
            IDLE: begin
                if (transfer) begin
                    data_d  = rng.RANGE_DATA;
                    err_d   = rng.RANGE_ERR;
                    prod_d  = '0;
                    state_d = rng.RANGE_ERR ? SMOOTH : PREP;
                end
            end
            PREP: begin
                if (data_q <= RANGE_MIN)      r_clamp = RANGE_MIN;
                else if (data_q >= RANGE_MAX) r_clamp = RANGE_MAX;
                else                          r_clamp = data_q;
                offset   = INVERT ? (RANGE_MAX - r_clamp) : (r_clamp - RANGE_MIN);
                mplier_d = offset;
                mcand_d  = MCAND;
                prod_d   = '0;
                rem_d    = '0;
                cnt_d    = '0;
                state_d  = MUL;
            end
            MUL: begin
                if (mplier_q[0]) prod_d = prod_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 6'd1;
                if (cnt_q == 6'd7) begin
                    cnt_d   = '0;
                    state_d = DIV;
                end
            end
            DIV: begin
                // Quotient bits shift into prod_q as dividend bits shift out.
                rem_sh = {rem_q, prod_q[40]};
                ge     = (rem_sh >= {1'b0, SPAN});
                rem_d  = ge ? 8'(rem_sh - {1'b0, SPAN}) : rem_sh[7:0];
                prod_d = {prod_q[39:0], ge};
                cnt_d  = cnt_q + 6'd1;
                if (cnt_q == 6'd40) begin
                    cnt_d   = '0;
                    state_d = SMOOTH;
                end
            end
            SMOOTH: begin
                target = err_q ? 33'd0 : prod_q[32:0];
                diff   = $signed({1'b0, target}) - $signed({2'b00, period_q});
                mag    = diff[33] ? 34'(-diff) : 34'(diff);
                step   = diff >>> SMOOTH_SHIFT;
                sum    = $signed({2'b00, period_q}) + step;
                if (err_q)                  period_d = '0;
                else if (SMOOTH_SHIFT == 0) period_d = target[31:0];
                else if (mag < SNAP)        period_d = target[31:0];
                else                        period_d = sum[31:0];
                update_d = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            data_q   <= '0;
            err_q    <= 1'b0;
            mplier_q <= '0;
            mcand_q  <= '0;
            prod_q   <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            period_q <= '0;
            update_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            err_q    <= err_d;
            mplier_q <= mplier_d;
            mcand_q  <= mcand_d;
            prod_q   <= prod_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            update_q <= update_d;
        end
    end

endmodule

// File: tb/tb_range_to_pwm.sv
// Drives three range_to_pwm configurations in lockstep and checks them against a reference model.
module tb_range_to_pwm;

    localparam longint TOP1 = 12000;
    localparam longint RMIN = 10;
    localparam longint RMAX = 200;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    range_to_pwm_if ifa ();
    range_to_pwm_if ifb ();
    range_to_pwm_if ifc ();

    logic [31:0] cnt_a, cnt_b, cnt_c;
    logic [31:0] per_a, per_b, per_c;
    logic        upd_a, upd_b, upd_c;
    logic        busy_a, busy_b, busy_c;

    range_to_pwm #(.PWM_TOP(32'd11999), .RANGE_MIN(8'd10), .RANGE_MAX(8'd200),
                   .INVERT(1'b1), .SMOOTH_SHIFT(0)) dut_a (
        .CLK(CLK), .RST(RST), .rng(ifa.slave), .PWM_COUNTER(cnt_a),
        .PWM_PERIOD(per_a), .UPDATE(upd_a), .BUSY(busy_a));

    range_to_pwm #(.PWM_TOP(32'd11999), .RANGE_MIN(8'd10), .RANGE_MAX(8'd200),
                   .INVERT(1'b0), .SMOOTH_SHIFT(0)) dut_b (
        .CLK(CLK), .RST(RST), .rng(ifb.slave), .PWM_COUNTER(cnt_b),
        .PWM_PERIOD(per_b), .UPDATE(upd_b), .BUSY(busy_b));

    range_to_pwm #(.PWM_TOP(32'd11999), .RANGE_MIN(8'd10), .RANGE_MAX(8'd200),
                   .INVERT(1'b1), .SMOOTH_SHIFT(2)) dut_c (
        .CLK(CLK), .RST(RST), .rng(ifc.slave), .PWM_COUNTER(cnt_c),
        .PWM_PERIOD(per_c), .UPDATE(upd_c), .BUSY(busy_c));

    int tests = 0;
    int fails = 0;
    int upd_seen_a = 0;
    longint m_a, m_b, m_c;

    always @(posedge upd_a) upd_seen_a <= upd_seen_a + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint tgt(input int d, input bit inv);
        longint r, off;
        r = d;
        if (r <= RMIN) r = RMIN;
        if (r >= RMAX) r = RMAX;
        off = inv ? (RMAX - r) : (r - RMIN);
        return (off * TOP1) / (RMAX - RMIN);
    endfunction

    // Exponential smoothing step with floor division and a snap window.
    function automatic longint smooth(input longint prev, input longint t, input int sh);
        longint d, ad, p2, st;
        if (sh == 0) return t;
        p2 = longint'(1) << sh;
        d  = t - prev;
        ad = (d < 0) ? -d : d;
        if (ad < p2) return t;
        st = (d >= 0) ? d / p2 : -((-d + p2 - 1) / p2);
        return prev + st;
    endfunction

    task automatic drive(input logic [7:0] d, input logic e, input logic v);
        ifa.RANGE_DATA = d; ifa.RANGE_ERR = e; ifa.RANGE_VALID = v;
        ifb.RANGE_DATA = d; ifb.RANGE_ERR = e; ifb.RANGE_VALID = v;
        ifc.RANGE_DATA = d; ifc.RANGE_ERR = e; ifc.RANGE_VALID = v;
    endtask

    task automatic sample(input logic [7:0] d, input bit e, input bit hold);
        int lat;
        bit seen, stable;
        logic [31:0] pa, pb, pc;
        int u0;
        chk("ready_before_E0", {ifa.RANGE_READY, ifb.RANGE_READY, ifc.RANGE_READY}, 3'b111);
        u0 = upd_seen_a;
        pa = per_a; pb = per_b; pc = per_c;
        drive(d, e, 1'b1);
        @(posedge CLK); #1;
        chk("ready_low_after_E0", {ifa.RANGE_READY, ifb.RANGE_READY, ifc.RANGE_READY}, 3'b000);
        chk("busy_after_E0", busy_a, 1);
        chk("no_update_at_E0", upd_a, 0);
        if (!hold) drive(8'($urandom), 1'($urandom), 1'b0);
        lat = 0; seen = 0; stable = 1;
        while (!seen && lat < 80) begin
            if (per_a !== pa || per_b !== pb || per_c !== pc) stable = 0;
            @(posedge CLK); #1;
            lat++;
            seen = upd_a;
        end
        chk("latency", lat, e ? 1 : 51);
        chk("period_stable_while_busy", stable, 1);
        if (e) begin
            m_a = 0; m_b = 0; m_c = 0;
        end else begin
            m_a = smooth(m_a, tgt(d, 1'b1), 0);
            m_b = smooth(m_b, tgt(d, 1'b0), 0);
            m_c = smooth(m_c, tgt(d, 1'b1), 2);
        end
        chk("period_a", per_a, m_a);
        chk("period_b", per_b, m_b);
        chk("period_c", per_c, m_c);
        chk("update_bc", {upd_b, upd_c}, 2'b11);
        chk("ready_in_update_cycle", ifa.RANGE_READY, 1);
        chk("one_pulse", upd_seen_a - u0, 1);
        if (!hold) begin
            @(posedge CLK); #1;
            chk("update_one_cycle", upd_a, 0);
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int u0;
        logic [7:0] rd;
        bit re;
        m_a = 0; m_b = 0; m_c = 0;
        RST = 1'b1;
        drive(8'd0, 1'b0, 1'b0);
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_period", {per_a, per_b, per_c}, 96'd0);
        chk("reset_update", {upd_a, upd_b, upd_c}, 3'b000);
        chk("reset_ready_forced_low", {ifa.RANGE_READY, ifb.RANGE_READY, ifc.RANGE_READY}, 3'b000);
        chk("reset_busy", busy_a, 0);
        chk("pwm_counter_in_reset", cnt_a, 11999);
        @(negedge CLK) RST = 1'b0;
        #1;
        chk("ready_after_reset", ifa.RANGE_READY, 1);

        sample(8'd10, 1'b0, 1'b0);
        chk("a_range10", per_a, 12000);
        chk("b_range10_noinvert", per_b, 0);
        chk("c_smooth1", per_c, 3000);
        sample(8'd10, 1'b0, 1'b0);
        chk("c_smooth2", per_c, 5250);
        sample(8'd10, 1'b0, 1'b0);
        chk("c_smooth3", per_c, 6937);
        sample(8'd10, 1'b0, 1'b0);
        chk("c_smooth4", per_c, 8202);

        sample(8'd105, 1'b0, 1'b0);
        chk("a_range105", per_a, 6000);
        sample(8'd0, 1'b1, 1'b0);
        chk("a_error_zero", per_a, 0);
        chk("c_error_bypass", per_c, 0);
        sample(8'd200, 1'b0, 1'b0);
        chk("a_range200", per_a, 0);
        chk("b_range200_noinvert", per_b, 12000);
        sample(8'd3, 1'b0, 1'b0);
        chk("a_clamp_low", per_a, 12000);
        sample(8'd255, 1'b0, 1'b0);
        chk("a_clamp_high", per_a, 0);
        chk("pwm_counter", {cnt_a, cnt_b, cnt_c}, {32'd11999, 32'd11999, 32'd11999});

        u0 = upd_seen_a;
        sample(8'd50, 1'b0, 1'b1);
        sample(8'd150, 1'b0, 1'b0);
        chk("backpressure_two_pulses", upd_seen_a - u0, 2);

        sample(8'd105, 1'b0, 1'b0);
        drive(8'd30, 1'b0, 1'b1);
        @(posedge CLK); #1;
        drive(8'd0, 1'b0, 1'b0);
        repeat (20) @(posedge CLK);
        #2;
        u0 = upd_seen_a;
        RST = 1'b1;
        #1;
        chk("async_reset_period", {per_a, per_b, per_c}, 96'd0);
        chk("async_reset_ready", {ifa.RANGE_READY, ifb.RANGE_READY, ifc.RANGE_READY}, 3'b000);
        repeat (3) @(posedge CLK);
        #1;
        @(negedge CLK) RST = 1'b0;
        #1;
        chk("ready_after_mid_reset", ifa.RANGE_READY, 1);
        chk("busy_after_mid_reset", busy_a, 0);
        repeat (60) @(posedge CLK);
        #1;
        chk("no_update_after_drop", upd_seen_a - u0, 0);
        chk("period_held_after_drop", per_a, 0);
        m_a = 0; m_b = 0; m_c = 0;

        repeat (40) begin
            sample(8'd10, 1'b0, 1'b0);
            chk("c_no_overshoot", per_c <= 32'd12000, 1);
        end
        chk("c_converged_snap", per_c, 12000);

        repeat (12) begin
            rd = 8'($urandom_range(0, 255));
            re = ($urandom_range(0, 7) == 0);
            sample(rd, re, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
